// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target peripheral: register offsets
// (addr[3:2]), STATUS/CTRL bit positions, reset constants and FSM states.
package spi_target_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_BUSY     = 4;
  localparam int STAT_OVR      = 8;
  localparam int STAT_UDR      = 9;
  localparam int STAT_TXOVF    = 10;
  localparam int STAT_EOF      = 11;
  localparam int STAT_CNT_LSB  = 16;

  localparam int CTRL_DUMMY_LSB = 0;
  localparam int CTRL_IE_RX     = 8;
  localparam int CTRL_IE_EOF    = 9;
  localparam int CTRL_IE_ERR    = 10;
  localparam int CTRL_CPHA      = 12;
  localparam int CTRL_CPOL      = 13;

  localparam logic [7:0] DUMMY_RST = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous byte FIFO used for both the RX and TX paths. A push while full
// is accepted only when a pop happens in the same cycle; pops while empty are
// ignored. The head entry is visible combinationally on head.
module spi_target_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_spi_target.sv
// SPI target with an AXI4-Lite register interface. sck/cs/mosi are
// synchronised into clk (f_clk >= 8*f_sck). Bytes received from the
// controller land in an RX FIFO; bytes returned on miso come from a TX FIFO,
// or CTRL.dummy when it is empty.
// Optional build macro SPI_TARGET_MODE_SEL_EN adds CPOL/CPHA selection in
// CTRL[13:12]; without it the block runs fixed SPI mode 0.
module axi_spi_target
  import spi_target_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  output logic              miso_oe,
  output logic              irq_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Synchroniser and edge-detect state
  logic [1:0] sck_ff, cs_ff, mosi_ff;
  logic       sck_prev, cs_prev;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  // SPI engine
  spi_state_t state, state_nx;
  logic       start, stop, do_sample, do_shift;
  logic       sample_edge, shift_edge;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic [7:0] rx_byte, load_byte;
  logic       load_pending;
  logic       frame_ok;
  logic       tx_load, byte_done, busy;
  logic       cpol, cpha;

  // FIFO interfaces
  logic [7:0]    rx_head, tx_head;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          spi_tx_pop, axi_rx_pop, axi_tx_push;

  // Registers
  logic [7:0] dummy;
  logic       ie_rx, ie_eof, ie_err;
  logic [3:0] sticky;
  logic [3:0] sticky_set, sticky_clr;
  logic       ovr_set, udr_set, txovf_set, eof_set;

  // AXI
  logic        wr_en, rd_en;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] rd_value, status_word, ctrl_word;
  logic        unused_bits;

  // Two-flop synchronisers followed by a registered previous value for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_ff   <= '0;
      cs_ff    <= '0;
      mosi_ff  <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b0;
    end else begin
      sck_ff   <= {sck_ff[0], sck};
      cs_ff    <= {cs_ff[0], cs};
      mosi_ff  <= {mosi_ff[0], mosi};
      sck_prev <= sck_ff[1];
      cs_prev  <= cs_ff[1];
    end
  end

  assign sck_s    = sck_ff[1];
  assign cs_s     = cs_ff[1];
  assign mosi_s   = mosi_ff[1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  // Modes 0 and 3 sample on rising sck, modes 1 and 2 on falling sck.
  assign sample_edge = (cpol ^ cpha) ? sck_fall : sck_rise;
  assign shift_edge  = (cpol ^ cpha) ? sck_rise : sck_fall;

  // SPI state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and per-cycle engine strobes; cs rise beats any sck edge.
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    stop      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && frame_ok) begin
          state_nx = SHIFT;
          start    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nx = IDLE;
          stop     = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state == SHIFT);
  assign byte_done  = do_sample && (bit_cnt == 3'd7);
  assign rx_byte    = {rx_shift[6:0], mosi_s};
  assign tx_load    = (start && !cpha) || (do_shift && load_pending);
  assign load_byte  = tx_empty ? dummy : tx_head;
  assign spi_tx_pop = tx_load && !tx_empty;
  assign udr_set    = tx_load && tx_empty;
  assign ovr_set    = byte_done && rx_full && !axi_rx_pop;
  assign eof_set    = stop;

  // Shift registers, bit counter, miso drive and the post-reset frame guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      load_pending <= 1'b0;
      frame_ok     <= 1'b0;
    end else begin
      if (cs_s) frame_ok <= 1'b1;
      if (start) begin
        bit_cnt      <= '0;
        miso_oe      <= 1'b1;
        load_pending <= cpha;
      end
      if (stop) begin
        bit_cnt      <= '0;
        miso_oe      <= 1'b0;
        miso         <= 1'b0;
        load_pending <= 1'b0;
      end
      if (do_sample) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) load_pending <= 1'b1;
      end
      if (tx_load) begin
        tx_shift     <= load_byte;
        miso         <= load_byte[7];
        load_pending <= 1'b0;
      end else if (do_shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        miso     <= tx_shift[6];
      end
    end
  end

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (byte_done),
    .push_data (rx_byte),
    .pop       (axi_rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (axi_tx_push),
    .push_data (s_axi_wdata[7:0]),
    .pop       (spi_tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign wr_en  = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign rd_en  = s_axi_arready && s_axi_arvalid;
  assign wr_sel = s_axi_awaddr[3:2];
  assign rd_sel = s_axi_araddr[3:2];

  assign axi_tx_push = wr_en && (wr_sel == REG_DATA) && s_axi_wstrb[0];
  assign txovf_set   = axi_tx_push && tx_full && !spi_tx_pop;
  assign axi_rx_pop  = rd_en && (rd_sel == REG_DATA) && !rx_empty;

  assign sticky_set = {eof_set, txovf_set, udr_set, ovr_set};
  assign sticky_clr = (wr_en && (wr_sel == REG_STATUS) && s_axi_wstrb[1]) ?
                      s_axi_wdata[STAT_EOF:STAT_OVR] : 4'b0000;

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  // AXI handshakes: single-cycle ready pulses, valids held until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wr_en)             s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_value;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // CTRL fields, sticky flags (set beats clear) and the registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      dummy   <= DUMMY_RST;
      ie_rx   <= 1'b0;
      ie_eof  <= 1'b0;
      ie_err  <= 1'b0;
      sticky  <= '0;
      irq_out <= 1'b0;
    end else begin
      if (wr_en && (wr_sel == REG_CTRL)) begin
        if (s_axi_wstrb[0]) dummy <= s_axi_wdata[CTRL_DUMMY_LSB +: 8];
        if (s_axi_wstrb[1]) begin
          ie_rx  <= s_axi_wdata[CTRL_IE_RX];
          ie_eof <= s_axi_wdata[CTRL_IE_EOF];
          ie_err <= s_axi_wdata[CTRL_IE_ERR];
        end
      end
      sticky  <= (sticky & ~sticky_clr) | sticky_set;
      irq_out <= (ie_rx & ~rx_empty) | (ie_eof & sticky[3]) | (ie_err & (|sticky[2:0]));
    end
  end

`ifdef SPI_TARGET_MODE_SEL_EN
  // SPI mode bits; changes are refused while a frame is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpol <= 1'b0;
      cpha <= 1'b0;
    end else if (wr_en && (wr_sel == REG_CTRL) && s_axi_wstrb[1] && !busy) begin
      cpol <= s_axi_wdata[CTRL_CPOL];
      cpha <= s_axi_wdata[CTRL_CPHA];
    end
  end
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  // Register read image assembled from live status and stored fields.
  always_comb begin
    status_word = '0;
    status_word[STAT_RX_EMPTY] = rx_empty;
    status_word[STAT_RX_FULL]  = rx_full;
    status_word[STAT_TX_EMPTY] = tx_empty;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_EOF:STAT_OVR] = sticky;
    status_word[STAT_CNT_LSB +: 8] = 8'(rx_count);

    ctrl_word = '0;
    ctrl_word[CTRL_DUMMY_LSB +: 8] = dummy;
    ctrl_word[CTRL_IE_RX]  = ie_rx;
    ctrl_word[CTRL_IE_EOF] = ie_eof;
    ctrl_word[CTRL_IE_ERR] = ie_err;
    ctrl_word[CTRL_CPHA]   = cpha;
    ctrl_word[CTRL_CPOL]   = cpol;

    rd_value = '0;
    case (rd_sel)
      REG_DATA:   rd_value = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_head};
      REG_STATUS: rd_value = status_word;
      REG_CTRL:   rd_value = ctrl_word;
      default:    rd_value = '0;
    endcase
  end

  assign unused_bits = ^{s_axi_awaddr[ADDR_W-1:4], s_axi_awaddr[1:0],
                         s_axi_araddr[ADDR_W-1:4], s_axi_araddr[1:0],
                         s_axi_wdata[31:11], s_axi_wstrb[3:2], tx_count};

endmodule

// File: tb/tb_axi_spi_target.sv
// Directed bench for axi_spi_target: a table of single-byte loopback frames
// plus hand-written sequences for multi-byte frames, overflow, partial
// frames, reset mid-frame and AXI back-pressure.
module tb_axi_spi_target;

  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 32;
  localparam int HALF       = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid, arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;
  logic              sck, mosi, cs;
  logic              miso, miso_oe, irq_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] mosi_q [16];
  logic [7:0] miso_q [16];
  logic       oe_seen;

  typedef struct {
    string      name;
    bit         tx_valid;
    logic [7:0] tx_byte;
    logic [7:0] dummy;
    logic [7:0] mosi_byte;
    logic [7:0] exp_miso;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  axi_spi_target #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .sck           (sck),
    .mosi          (mosi),
    .cs            (cs),
    .miso          (miso),
    .miso_oe       (miso_oe),
    .irq_out       (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s got=timeout exp=handshake", name);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) begin
      fail_timeout("awready");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) fail_timeout("bvalid");
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n;
    data = '0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) begin
      fail_timeout("arready");
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin
      fail_timeout("rvalid");
      return;
    end
    data = rdata;
    @(negedge clk);
  endtask

  // Mode 0 controller: mosi changes with sck low, miso captured just before rise.
  task automatic spi_frame(input int nbits);
    cs = 1'b0;
    oe_seen = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      mosi = mosi_q[b/8][7-(b%8)];
      repeat (HALF) @(negedge clk);
      miso_q[b/8][7-(b%8)] = miso;
      if (b == 0) oe_seen = miso_oe;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [31:0] rd;
    axi_write(32'h8, {24'h0, v.dummy});
    if (v.tx_valid) axi_write(32'h0, {24'h0, v.tx_byte});
    mosi_q[0] = v.mosi_byte;
    spi_frame(8);
    repeat (HALF) @(negedge clk);
    check_output({v.name, "_miso"}, {24'h0, miso_q[0]}, {24'h0, v.exp_miso});
    axi_read(32'h0, rd);
    check_output({v.name, "_rdata"}, rd, v.exp_rdata);
    axi_write(32'h4, 32'h0000_0F00);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    bit saw;

    vecs[0] = '{"vec_a5",    1'b1, 8'hA5, 8'hFF, 8'h12, 8'hA5, 32'h0000_0112};
    vecs[1] = '{"vec_zero",  1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'h0000_01FF};
    vecs[2] = '{"vec_dummy", 1'b0, 8'h00, 8'h5A, 8'h80, 8'h5A, 32'h0000_0180};
    vecs[3] = '{"vec_81",    1'b1, 8'h81, 8'h00, 8'h01, 8'h81, 32'h0000_0101};

    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    sck = 1'b0; mosi = 1'b0; cs = 1'b1;
    do_reset();

    // Reset state
    check_output("reset_outputs",
                 {17'h0, awready, wready, bvalid, bresp, arready, rvalid, rresp, miso, miso_oe, irq_out},
                 32'h0);
    check_output("reset_rdata", rdata, 32'h0);
    axi_read(32'h4, rd);
    check_output("reset_status", rd, 32'h0000_0005);
    axi_read(32'h8, rd);
    check_output("reset_ctrl", rd, 32'h0000_00FF);
    axi_read(32'hC, rd);
    check_output("rsvd_read", rd, 32'h0);

    // Table of single-byte loopback frames
    for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);
    axi_write(32'h8, 32'h0000_00FF);

    // Two-byte frame from a preloaded TX FIFO
    axi_write(32'h0, 32'h0000_00A5);
    axi_write(32'h0, 32'h0000_003C);
    mosi_q[0] = 8'h12;
    mosi_q[1] = 8'h34;
    spi_frame(16);
    repeat (HALF) @(negedge clk);
    check_output("two_byte_oe", {31'h0, oe_seen}, 32'h1);
    check_output("two_byte_miso0", {24'h0, miso_q[0]}, 32'h0000_00A5);
    check_output("two_byte_miso1", {24'h0, miso_q[1]}, 32'h0000_003C);
    check_output("oe_after_frame", {31'h0, miso_oe}, 32'h0);
    axi_read(32'h0, rd);
    check_output("two_byte_rd0", rd, 32'h0000_0112);
    axi_read(32'h0, rd);
    check_output("two_byte_rd1", rd, 32'h0000_0134);
    axi_read(32'h0, rd);
    check_output("two_byte_rd_empty", rd, 32'h0);
    axi_write(32'h4, 32'h0000_0F00);

    // Underrun sends the dummy byte and sets UDR; W1C clears it
    axi_write(32'h8, 32'h0000_005A);
    mosi_q[0] = 8'hC0;
    spi_frame(8);
    repeat (HALF) @(negedge clk);
    check_output("udr_miso", {24'h0, miso_q[0]}, 32'h0000_005A);
    axi_read(32'h4, rd);
    check_output("udr_set", {31'h0, rd[9]}, 32'h1);
    axi_write(32'h4, 32'h0000_0200);
    axi_read(32'h4, rd);
    check_output("udr_cleared", {31'h0, rd[9]}, 32'h0);
    axi_read(32'h0, rd);
    check_output("udr_rx", rd, 32'h0000_01C0);
    axi_write(32'h4, 32'h0000_0F00);
    axi_write(32'h8, 32'h0000_00FF);

    // RX overflow: FIFO_DEPTH+1 bytes without reading
    for (int i = 0; i <= FIFO_DEPTH; i++) mosi_q[i] = 8'h10 + 8'(i);
    spi_frame(8 * (FIFO_DEPTH + 1));
    repeat (HALF) @(negedge clk);
    axi_read(32'h4, rd);
    check_output("ovr_status", rd & 32'h00FF_0103, 32'h0008_0102);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      axi_read(32'h0, rd);
      check_output($sformatf("ovr_rd%0d", i), rd, 32'h0000_0100 | {24'h0, 8'h10 + 8'(i)});
    end
    axi_read(32'h0, rd);
    check_output("ovr_ninth_lost", rd, 32'h0);
    axi_write(32'h4, 32'h0000_0F00);

    // Partial frame: cs rises after 5 bits, EOF interrupt
    axi_write(32'h8, 32'h0000_02FF);
    mosi_q[0] = 8'hAA;
    spi_frame(5);
    n = 0;
    while (!irq_out && n < 8) begin @(negedge clk); n++; end
    check_output("partial_irq", {31'h0, irq_out}, 32'h1);
    axi_read(32'h4, rd);
    check_output("partial_status", rd & 32'h00FF_0801, 32'h0000_0801);
    axi_write(32'h4, 32'h0000_0F00);
    repeat (2) @(negedge clk);
    check_output("partial_irq_clear", {31'h0, irq_out}, 32'h0);
    axi_write(32'h8, 32'h0000_00FF);

    // Reset mid-byte with cs held low: further edges ignored
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      mosi = b[0];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    do_reset();
    check_output("midreset_oe", {31'h0, miso_oe}, 32'h0);
    for (int b = 0; b < 8; b++) begin
      mosi = ~b[0];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (HALF) @(negedge clk);
    axi_read(32'h4, rd);
    check_output("midreset_status", rd & 32'h00FF_0801, 32'h0000_0001);
    axi_write(32'h0, 32'h0000_00C3);
    mosi_q[0] = 8'h66;
    spi_frame(8);
    repeat (HALF) @(negedge clk);
    check_output("postreset_miso", {24'h0, miso_q[0]}, 32'h0000_00C3);
    axi_read(32'h0, rd);
    check_output("postreset_rd", rd, 32'h0000_0166);
    axi_write(32'h4, 32'h0000_0F00);

    // Read back-pressure: rdata/rvalid hold while SPI traffic runs
    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) fail_timeout("bp_arready");
    @(negedge clk);
    arvalid = 1'b0;
    mosi_q[0] = 8'h5C;
    fork
      spi_frame(8);
      begin
        for (int k = 0; k < 5; k++) begin
          repeat (10) @(negedge clk);
          check_output($sformatf("bp_rvalid%0d", k), {31'h0, rvalid}, 32'h1);
          check_output($sformatf("bp_rdata%0d", k), rdata, 32'h0000_00FF);
        end
      end
    join
    repeat (HALF) @(negedge clk);
    check_output("bp_rdata_end", rdata, 32'h0000_00FF);
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("bp_rvalid_drop", {31'h0, rvalid}, 32'h0);
    check_output("bp_miso", {24'h0, miso_q[0]}, 32'h0000_00FF);
    axi_read(32'h0, rd);
    check_output("bp_rx", rd, 32'h0000_015C);

    // Write back-pressure: bvalid held, next awready blocked
    @(negedge clk);
    awaddr = 32'h8; wdata = 32'h0000_00AB; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) fail_timeout("bp_awready");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    wdata = 32'h0000_00FF; awvalid = 1'b1; wvalid = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (awready) saw = 1'b1;
    end
    check_output("bp_aw_blocked", {31'h0, saw}, 32'h0);
    check_output("bp_bvalid_held", {31'h0, bvalid}, 32'h1);
    bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) fail_timeout("bp_awready2");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) @(negedge clk);
    axi_read(32'h8, rd);
    check_output("bp_ctrl_final", rd, 32'h0000_00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
